// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the RISK-IV control sequencer: state encodings and
// default datapath constants.
package cpu_sequencer_pkg;

  localparam int unsigned DEFAULT_WORD = 16;
  localparam int unsigned OPSIZE       = 4;

  // Numeric values are visible on the debug state port, so keep them fixed.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_WAIT   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_sequencer_wb_tracker.sv
// Write-back channel tracker: loads the pending mask, pulses wb_go once and
// retires channels as their acks arrive.
module wb_tracker #(
  parameter int unsigned NWB = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [NWB-1:0] wb_req,
  input  logic           track,
  input  logic [NWB-1:0] wb_ack,
  output logic [NWB-1:0] wb_go,
  output logic           all_done
);

  logic [NWB-1:0] pending;
  logic [NWB-1:0] remaining;

  // all_done looks at the mask after this cycle's acks, so completion does not
  // wait an extra cycle for the register to update.
  assign remaining = pending & ~wb_ack;
  assign all_done  = (remaining == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      wb_go   <= '0;
    end else begin
      wb_go <= load ? wb_req : '0;
      if (load) begin
        pending <= wb_req;
      end else if (track) begin
        pending <= remaining;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, steps fetch/decode/execute,
// waits for write-back acks, then applies jumps and counts retirements.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned     WORD     = DEFAULT_WORD,
  parameter int unsigned     NWB      = 3,
  parameter int unsigned     PC_STEP  = 2,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  output logic            fetch_req,
  input  logic            fetch_done,
  input  logic [WORD-1:0] instr,
  output logic [WORD-1:0] ir,
  output logic [WORD-1:0] pc,
  output logic            decode_en,
  output logic            exec_en,
  input  logic            exec_done,
  input  logic [NWB-1:0]  wb_req,
  input  logic            jump,
  input  logic            rjump,
  input  logic [WORD-1:0] jump_loc,
  input  logic [WORD-1:0] jump_inc,
  output logic [NWB-1:0]  wb_go,
  input  logic [NWB-1:0]  wb_ack,
  output logic            retired,
  output logic [WORD-1:0] retire_count,
  output logic            halted,
  output logic [2:0]      state
);

  localparam logic [WORD-1:0] STEP_W = WORD'(PC_STEP);

  state_t          cur;
  logic            jump_q;
  logic            rjump_q;
  logic [WORD-1:0] jump_loc_q;
  logic [WORD-1:0] jump_inc_q;
  logic            wb_load;
  logic            wb_track;
  logic            wb_all_done;
  logic [WORD-1:0] abs_target;
  logic [WORD-1:0] rel_target;

  assign wb_load  = (cur == S_EXEC) && exec_done;
  assign wb_track = (cur == S_WAIT);

  wb_tracker #(.NWB(NWB)) u_wb_tracker (
    .clk      (clk),
    .rst      (rst),
    .load     (wb_load),
    .wb_req   (wb_req),
    .track    (wb_track),
    .wb_ack   (wb_ack),
    .wb_go    (wb_go),
    .all_done (wb_all_done)
  );

  // Truncated WORD-wide products give the same bits as the signed product;
  // the -STEP_W undoes the increment already applied in DECODE.
  assign abs_target = jump_loc_q * STEP_W;
  assign rel_target = pc + jump_inc_q * STEP_W - STEP_W;

  assign fetch_req = (cur == S_FETCH);
  assign decode_en = (cur == S_DECODE);
  assign exec_en   = (cur == S_EXEC);
  assign halted    = (cur == S_HALTED);
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      retire_count <= '0;
      retired      <= 1'b0;
      jump_q       <= 1'b0;
      rjump_q      <= 1'b0;
      jump_loc_q   <= '0;
      jump_inc_q   <= '0;
    end else begin
      retired <= 1'b0;
      case (cur)
        S_FETCH: begin
          if (fetch_done) begin
            ir  <= instr;
            cur <= S_DECODE;
          end
        end
        S_DECODE: begin
          pc  <= pc + STEP_W;
          cur <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            jump_q     <= jump;
            rjump_q    <= rjump;
            jump_loc_q <= jump_loc;
            jump_inc_q <= jump_inc;
            cur        <= S_WB;
          end
        end
        S_WB: begin
          cur <= S_WAIT;
        end
        S_WAIT: begin
          if (wb_all_done) begin
            if (jump_q) begin
              pc <= abs_target;
            end else if (rjump_q) begin
              pc <= rel_target;
            end
            retired      <= 1'b1;
            retire_count <= retire_count + WORD'(1);
            cur          <= halt ? S_HALTED : S_FETCH;
          end
        end
        S_HALTED: begin
          if (!halt) begin
            cur <= S_FETCH;
          end
        end
        default: begin
          cur <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: drives fetch/exec/write-back handshakes and checks
// PC, IR, retire timing and counts against an instruction-level model.
module tb_cpu_sequencer;

  localparam int WORD    = 16;
  localparam int NWB     = 3;
  localparam int PC_STEP = 2;

  logic              clk = 1'b0;
  logic              rst, halt, fetch_done, exec_done, jump, rjump;
  logic [WORD-1:0]   instr, jump_loc, jump_inc;
  logic [NWB-1:0]    wb_req, wb_ack;
  logic              fetch_req, decode_en, exec_en, retired, halted;
  logic [WORD-1:0]   ir, pc, retire_count;
  logic [NWB-1:0]    wb_go;
  logic [2:0]        state;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [WORD-1:0] m_pc, m_cnt;

  logic [WORD-1:0] o_fetch_pc, o_ir, o_exec_pc, o_pc, o_cnt;
  logic            o_freq, o_dec, o_dec2, o_pc_hold, o_halted;
  logic [NWB-1:0]  o_wbgo, o_wbgo_wait;
  int              o_wait, o_retire_cyc;

  cpu_sequencer #(
    .WORD    (WORD),
    .NWB     (NWB),
    .PC_STEP (PC_STEP),
    .RESET_PC(16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .fetch_req    (fetch_req),
    .fetch_done   (fetch_done),
    .instr        (instr),
    .ir           (ir),
    .pc           (pc),
    .decode_en    (decode_en),
    .exec_en      (exec_en),
    .exec_done    (exec_done),
    .wb_req       (wb_req),
    .jump         (jump),
    .rjump        (rjump),
    .jump_loc     (jump_loc),
    .jump_inc     (jump_inc),
    .wb_go        (wb_go),
    .wb_ack       (wb_ack),
    .retired      (retired),
    .retire_count (retire_count),
    .halted       (halted),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural PC after an instruction fetched at cur_pc.
  function automatic logic [WORD-1:0] next_pc(input logic [WORD-1:0] cur_pc,
      input logic j, input logic rj, input logic [WORD-1:0] loc,
      input logic [WORD-1:0] inc);
    int off;
    if (j) return WORD'(int'(loc) * PC_STEP);
    if (rj) begin
      off = int'($signed(inc));
      return WORD'(int'(cur_pc) + off * PC_STEP);
    end
    return WORD'(int'(cur_pc) + PC_STEP);
  endfunction

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; fetch_done = 1'b0; exec_done = 1'b0;
    jump = 1'b0; rjump = 1'b0; instr = '0; jump_loc = '0; jump_inc = '0;
    wb_req = '0; wb_ack = '0;
    step();
    step();
    rst = 1'b0;
    m_pc = '0;
    m_cnt = '0;
  endtask

  // dly holds a 4-bit WAIT-cycle index per channel at which that channel acks.
  task automatic run_instr(input logic [WORD-1:0] ins, input logic [NWB-1:0] req,
      input logic j, input logic rj, input logic [WORD-1:0] loc,
      input logic [WORD-1:0] inc, input int fl, input int el,
      input logic [11:0] dly, input logic [NWB-1:0] stray, input logic noise,
      input logic hlt_mid);
    logic [NWB-1:0] a;
    o_fetch_pc = pc;
    o_freq = fetch_req;
    for (int k = 0; k < fl; k++) step();
    fetch_done = 1'b1; instr = ins;
    step();
    fetch_done = 1'b0; instr = 16'($urandom);
    o_dec = decode_en; o_ir = ir;
    step();
    o_dec2 = decode_en; o_exec_pc = pc;
    if (hlt_mid) halt = 1'b1;
    for (int k = 0; k < el; k++) step();
    exec_done = 1'b1; wb_req = req; jump = j; rjump = rj;
    jump_loc = loc; jump_inc = inc;
    step();
    exec_done = 1'b0; wb_req = 3'($urandom); jump = 1'($urandom);
    rjump = 1'($urandom); jump_loc = 16'($urandom); jump_inc = 16'($urandom);
    o_wbgo = wb_go;
    if (noise) wb_ack = '1;
    step();
    wb_ack = '0;
    o_wbgo_wait = wb_go;
    o_pc_hold = 1'b1;
    o_wait = -1;
    for (int k = 0; k < 16; k++) begin
      a = stray & {NWB{k == 1}};
      for (int b = 0; b < NWB; b++)
        if (req[b] && int'(dly[b*4 +: 4]) == k) a[b] = 1'b1;
      wb_ack = a;
      if (pc !== o_exec_pc) o_pc_hold = 1'b0;
      step();
      if (retired) begin
        o_wait = k + 1;
        break;
      end
    end
    wb_ack = '0;
    o_pc = pc; o_cnt = retire_count; o_retire_cyc = cyc; o_halted = halted;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; fetch_done = 1'b0; exec_done = 1'b0;
    jump = 1'b0; rjump = 1'b0; instr = '0; jump_loc = '0; jump_inc = '0;
    wb_req = '0; wb_ack = '0;
    step();
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    vectors++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected 0000", ir); end
    vectors++; if (retire_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", retire_count); end
    vectors++; if ({retired, decode_en, exec_en, halted, wb_go} !== 7'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000000", {retired, decode_en, exec_en, halted, wb_go});
    end
    rst = 1'b0;
    m_pc = '0;
    m_cnt = '0;
  endtask

  task automatic test_straight();
    logic [WORD-1:0] ins;
    int prev_cyc;
    prev_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      ins = 16'($urandom);
      run_instr(ins, 3'b001, 1'b0, 1'b0, '0, '0, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
      vectors++; if (o_fetch_pc !== m_pc || o_freq !== 1'b1) begin
        errors++; $display("FAIL straight_fetch[%0d]: got pc %h req %b expected pc %h req 1", i, o_fetch_pc, o_freq, m_pc);
      end
      vectors++; if (o_ir !== ins) begin errors++; $display("FAIL straight_ir[%0d]: got %h expected %h", i, o_ir, ins); end
      vectors++; if (o_dec !== 1'b1 || o_dec2 !== 1'b0) begin
        errors++; $display("FAIL straight_decode_pulse[%0d]: got %b%b expected 10", i, o_dec, o_dec2);
      end
      vectors++; if (o_wbgo !== 3'b001 || o_wbgo_wait !== 3'b000) begin
        errors++; $display("FAIL straight_wb_go[%0d]: got %b/%b expected 001/000", i, o_wbgo, o_wbgo_wait);
      end
      m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
      m_cnt = m_cnt + 16'd1;
      vectors++; if (o_pc !== m_pc) begin errors++; $display("FAIL straight_pc[%0d]: got %h expected %h", i, o_pc, m_pc); end
      vectors++; if (o_cnt !== m_cnt) begin errors++; $display("FAIL straight_count[%0d]: got %0d expected %0d", i, o_cnt, m_cnt); end
      if (i > 0) begin
        vectors++; if (o_retire_cyc - prev_cyc !== 5) begin
          errors++; $display("FAIL straight_spacing[%0d]: got %0d expected 5", i, o_retire_cyc - prev_cyc);
        end
      end
      prev_cyc = o_retire_cyc;
    end
  endtask

  task automatic test_staggered();
    // bit0 acks in WAIT cycle 0, bit2 in 1, bit1 in 2; stray bit0 in cycle 1.
    run_instr(16'h1234, 3'b111, 1'b0, 1'b0, '0, '0, 1, 1, 12'h120, 3'b001, 1'b1, 1'b0);
    m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
    m_cnt = m_cnt + 16'd1;
    vectors++; if (o_wait !== 3) begin errors++; $display("FAIL staggered_wait: got %0d expected 3", o_wait); end
    vectors++; if (o_wbgo !== 3'b111) begin errors++; $display("FAIL staggered_wb_go: got %b expected 111", o_wbgo); end
    vectors++; if (o_pc !== m_pc) begin errors++; $display("FAIL staggered_pc: got %h expected %h", o_pc, m_pc); end
    vectors++; if (o_cnt !== m_cnt) begin errors++; $display("FAIL staggered_count: got %0d expected %0d", o_cnt, m_cnt); end
  endtask

  task automatic test_abs_jump();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_instr(16'($urandom), 3'b000, 1'b0, 1'b0, '0, '0, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
      m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
      m_cnt = m_cnt + 16'd1;
    end
    vectors++; if (o_pc !== 16'd4) begin errors++; $display("FAIL absjump_setup_pc: got %h expected 0004", o_pc); end
    run_instr(16'hABCD, 3'b010, 1'b1, 1'b0, 16'd10, '0, 0, 0, 12'h020, 3'b000, 1'b0, 1'b0);
    m_pc = next_pc(m_pc, 1'b1, 1'b0, 16'd10, '0);
    m_cnt = m_cnt + 16'd1;
    vectors++; if (o_exec_pc !== 16'd6 || o_pc_hold !== 1'b1) begin
      errors++; $display("FAIL absjump_hold: got pc %h stable %b expected 0006 stable 1", o_exec_pc, o_pc_hold);
    end
    vectors++; if (o_wait !== 3) begin errors++; $display("FAIL absjump_wait: got %0d expected 3", o_wait); end
    vectors++; if (o_pc !== m_pc) begin errors++; $display("FAIL absjump_pc: got %h expected %h", o_pc, m_pc); end
    run_instr(16'($urandom), 3'b000, 1'b0, 1'b0, '0, '0, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
    vectors++; if (o_fetch_pc !== 16'd20) begin errors++; $display("FAIL absjump_next_fetch: got %h expected 0014", o_fetch_pc); end
    m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic test_rel_jump();
    logic [WORD-1:0] incs [2];
    incs[0] = 16'hFFFE;
    incs[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      run_instr(16'($urandom), 3'b000, 1'b1, 1'b0, 16'd4, '0, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
      m_pc = next_pc(m_pc, 1'b1, 1'b0, 16'd4, '0);
      m_cnt = m_cnt + 16'd1;
      vectors++; if (o_pc !== 16'd8) begin errors++; $display("FAIL reljump_setup_pc[%0d]: got %h expected 0008", i, o_pc); end
      run_instr(16'($urandom), 3'b100, 1'b0, 1'b1, 16'($urandom), incs[i], 0, 1, 12'h100, 3'b000, 1'b0, 1'b0);
      m_pc = next_pc(m_pc, 1'b0, 1'b1, '0, incs[i]);
      m_cnt = m_cnt + 16'd1;
      vectors++; if (o_pc !== m_pc) begin errors++; $display("FAIL reljump_pc[%0d]: got %h expected %h", i, o_pc, m_pc); end
    end
    // Both flags: absolute jump wins.
    run_instr(16'($urandom), 3'b000, 1'b1, 1'b1, 16'd50, 16'd3, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
    m_pc = next_pc(m_pc, 1'b1, 1'b1, 16'd50, 16'd3);
    m_cnt = m_cnt + 16'd1;
    vectors++; if (o_pc !== 16'd100) begin errors++; $display("FAIL jump_priority_pc: got %h expected 0064", o_pc); end
  endtask

  task automatic test_random();
    logic [WORD-1:0] ins, loc, inc;
    logic [NWB-1:0]  req, stray;
    logic [11:0]     dly;
    logic            j, rj, noise;
    int              fl, el, mx, exp_wait;
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom); loc = 16'($urandom); inc = 16'($urandom);
      req = 3'($urandom); stray = 3'($urandom) & ~req;
      dly = '0;
      for (int b = 0; b < NWB; b++) dly[b*4 +: 4] = 4'($urandom_range(0, 3));
      j = ($urandom_range(0, 3) == 0); rj = ($urandom_range(0, 2) == 0);
      noise = 1'($urandom);
      fl = $urandom_range(0, 2); el = $urandom_range(0, 2);
      mx = 0;
      for (int b = 0; b < NWB; b++)
        if (req[b] && int'(dly[b*4 +: 4]) > mx) mx = int'(dly[b*4 +: 4]);
      exp_wait = mx + 1;
      run_instr(ins, req, j, rj, loc, inc, fl, el, dly, stray, noise, 1'b0);
      vectors++; if (o_fetch_pc !== m_pc) begin errors++; $display("FAIL rand_fetch_pc[%0d]: got %h expected %h", i, o_fetch_pc, m_pc); end
      vectors++; if (o_ir !== ins) begin errors++; $display("FAIL rand_ir[%0d]: got %h expected %h", i, o_ir, ins); end
      vectors++; if (o_wbgo !== req) begin errors++; $display("FAIL rand_wb_go[%0d]: got %b expected %b", i, o_wbgo, req); end
      vectors++; if (o_wait !== exp_wait || o_pc_hold !== 1'b1) begin
        errors++; $display("FAIL rand_wait[%0d]: got %0d stable %b expected %0d stable 1", i, o_wait, o_pc_hold, exp_wait);
      end
      m_pc = next_pc(m_pc, j, rj, loc, inc);
      m_cnt = m_cnt + 16'd1;
      vectors++; if (o_pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, o_pc, m_pc); end
      vectors++; if (o_cnt !== m_cnt) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, o_cnt, m_cnt); end
    end
  endtask

  task automatic test_halt();
    run_instr(16'h00AA, 3'b011, 1'b0, 1'b0, '0, '0, 0, 1, 12'h011, 3'b000, 1'b0, 1'b1);
    m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
    m_cnt = m_cnt + 16'd1;
    vectors++; if (o_cnt !== m_cnt) begin errors++; $display("FAIL halt_retired_count: got %0d expected %0d", o_cnt, m_cnt); end
    vectors++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_entered: got %b expected 1", o_halted); end
    for (int k = 0; k < 3; k++) begin
      fetch_done = 1'b1; exec_done = 1'b1;
      step();
      vectors++; if (pc !== m_pc || halted !== 1'b1 || {fetch_req, decode_en, exec_en} !== 3'b000) begin
        errors++; $display("FAIL halt_hold[%0d]: got pc %h halted %b en %b expected pc %h halted 1 en 000",
                           k, pc, halted, {fetch_req, decode_en, exec_en}, m_pc);
      end
    end
    fetch_done = 1'b0; exec_done = 1'b0;
    halt = 1'b0;
    step();
    vectors++; if (fetch_req !== 1'b1 || halted !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL halt_release: got req %b halted %b state %0d expected 1 0 0", fetch_req, halted, state);
    end
  endtask

  task automatic test_reset_mid();
    fetch_done = 1'b1; step(); fetch_done = 1'b0;
    step();
    exec_done = 1'b1; wb_req = 3'b011; step(); exec_done = 1'b0; wb_req = '0;
    step();
    wb_ack = '0; step();
    vectors++; if (state !== 3'd4) begin errors++; $display("FAIL midreset_in_wait: got state %0d expected 4", state); end
    rst = 1'b1; wb_ack = 3'b011;
    step();
    rst = 1'b0;
    m_pc = '0; m_cnt = '0;
    vectors++; if (pc !== 16'h0000 || state !== 3'd0 || ir !== 16'h0000 || retire_count !== 16'h0000) begin
      errors++; $display("FAIL midreset_values: got pc %h state %0d ir %h count %0d expected 0000 0 0000 0", pc, state, ir, retire_count);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (retired !== 1'b0 || fetch_req !== 1'b1 || retire_count !== 16'h0000) begin
        errors++; $display("FAIL midreset_late_ack[%0d]: got retired %b req %b count %0d expected 0 1 0", k, retired, fetch_req, retire_count);
      end
    end
    wb_ack = '0;
    run_instr(16'h5A5A, 3'b001, 1'b0, 1'b0, '0, '0, 0, 0, 12'h000, 3'b000, 1'b0, 1'b0);
    m_pc = next_pc(m_pc, 1'b0, 1'b0, '0, '0);
    m_cnt = m_cnt + 16'd1;
    vectors++; if (o_pc !== m_pc || o_cnt !== m_cnt) begin
      errors++; $display("FAIL midreset_recover: got pc %h count %0d expected %h %0d", o_pc, o_cnt, m_pc, m_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_staggered();
    test_abs_jump();
    test_rel_jump();
    test_random();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
